// File: rtl/alu_unit.sv
// Registered two-operand ALU: ADD/SUB/AND/OR with a one-bit-wider result.
// Optional macro ALU_FLAGS_EN adds registered ZERO_FLAG and CARRY_FLAG outputs.
module alu_unit #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ALU_FUN,
`ifdef ALU_FLAGS_EN
  output logic             ZERO_FLAG,
  output logic             CARRY_FLAG,
`endif
  output logic [WIDTH:0]   ALU_OUT
);

  logic [WIDTH:0] result_d;
  logic [WIDTH:0] result_q;

  // Operation decode; SUB wraps in WIDTH+1 bits so the MSB becomes the borrow.
  always_comb begin
    result_d = '0;
    if (RST) begin
      result_d = '0;
    end else begin
      case (ALU_FUN)
        2'b00:   result_d = {1'b0, A} + {1'b0, B};
        2'b01:   result_d = {1'b0, A} - {1'b0, B};
        2'b10:   result_d = {1'b0, A & B};
        2'b11:   result_d = {1'b0, A | B};
        default: result_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign ALU_OUT = result_q;

`ifdef ALU_FLAGS_EN
  logic zero_d;
  logic zero_q;
  logic carry_d;
  logic carry_q;

  // Flags describe the value about to be registered, so they line up with ALU_OUT.
  always_comb begin
    zero_d  = 1'b0;
    carry_d = 1'b0;
    if (RST) begin
      zero_d  = 1'b0;
      carry_d = 1'b0;
    end else begin
      zero_d  = (result_d == '0);
      carry_d = result_d[WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign ZERO_FLAG  = zero_q;
  assign CARRY_FLAG = carry_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed test-plan steps plus random
// operations with a mid-stream reset, checked against an arithmetic model.
module tb_alu_unit;

  localparam int WIDTH = 16;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       ALU_FUN;
  logic [WIDTH:0]   ALU_OUT;
`ifdef ALU_FLAGS_EN
  logic             ZERO_FLAG;
  logic             CARRY_FLAG;
`endif

  int tests_run;
  int tests_failed;

  alu_unit #(.WIDTH(WIDTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .A(A),
    .B(B),
    .ALU_FUN(ALU_FUN),
`ifdef ALU_FLAGS_EN
    .ZERO_FLAG(ZERO_FLAG),
    .CARRY_FLAG(CARRY_FLAG),
`endif
    .ALU_OUT(ALU_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: plain unsigned arithmetic, result modulo 2^(WIDTH+1).
  function automatic logic [WIDTH:0] model(input int unsigned a, input int unsigned b,
                                           input int unsigned fun);
    int unsigned r;
    int unsigned modulus;
    modulus = 32'd1 << (WIDTH + 1);
    case (fun)
      0:       r = a + b;
      1:       r = (a + modulus - b) % modulus;
      2:       r = a & b;
      default: r = a | b;
    endcase
    return r[WIDTH:0];
  endfunction

  task automatic check(input string tag, input logic [WIDTH:0] exp);
    tests_run++;
    assert (ALU_OUT === exp) else begin
      tests_failed++;
      $error("FAIL %s: ALU_OUT observed %h expected %h", tag, ALU_OUT, exp);
    end
`ifdef ALU_FLAGS_EN
    tests_run++;
    assert (ZERO_FLAG === (exp == '0)) else begin
      tests_failed++;
      $error("FAIL %s_zero: observed %b expected %b", tag, ZERO_FLAG, (exp == '0));
    end
    tests_run++;
    assert (CARRY_FLAG === exp[WIDTH]) else begin
      tests_failed++;
      $error("FAIL %s_carry: observed %b expected %b", tag, CARRY_FLAG, exp[WIDTH]);
    end
`endif
  endtask

  // Present one operation, clock it in, then check one time unit after the edge.
  task automatic step(input string tag, input logic rst, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [1:0] fun,
                      input logic [WIDTH:0] exp);
    RST     = rst;
    A       = a;
    B       = b;
    ALU_FUN = fun;
    @(posedge CLK);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [1:0]       rf;
    logic [WIDTH:0]   exp;
    tests_run    = 0;
    tests_failed = 0;

    // Reset discards the operation presented with it.
    step("reset", 1'b1, 16'h00B0, 16'h0033, 2'b00, 17'h00000);
    step("post_reset_add", 1'b0, 16'h00B0, 16'h0033, 2'b00, 17'h000E3);

    step("add_carry", 1'b0, 16'hFFFF, 16'h0001, 2'b00, 17'h10000);
    step("sub_borrow", 1'b0, 16'h0003, 16'h00A5, 2'b01, 17'h1FF5E);
    step("sub_equal", 1'b0, 16'h0045, 16'h0045, 2'b01, 17'h00000);
    step("and", 1'b0, 16'h00B0, 16'h0033, 2'b10, 17'h00030);
    step("or", 1'b0, 16'h00CF, 16'h0082, 2'b11, 17'h000CF);
    step("add_max", 1'b0, 16'hFFFF, 16'hFFFF, 2'b00, 17'h1FFFE);
    step("sub_0_minus_1", 1'b0, 16'h0000, 16'h0001, 2'b01, 17'h1FFFF);
    step("and_ones", 1'b0, 16'hFFFF, 16'hFFFF, 2'b10, 17'h0FFFF);
    step("or_ones", 1'b0, 16'hFFFF, 16'h0000, 2'b11, 17'h0FFFF);

    // Back-to-back with no bubbles.
    step("b2b_add", 1'b0, 16'h0031, 16'h0033, 2'b00, 17'h00064);
    step("b2b_sub", 1'b0, 16'h00E6, 16'h001B, 2'b01, 17'h000CB);

    // Result is held until the next edge even if inputs change.
    A       = 16'h1234;
    B       = 16'h4321;
    ALU_FUN = 2'b00;
    #3;
    check("hold", 17'h000CB);

    // Random stream with a reset in the middle.
    for (int i = 0; i < 60; i++) begin
      ra = WIDTH'($urandom_range(0, 65535));
      rb = WIDTH'($urandom_range(0, 65535));
      rf = 2'($urandom_range(0, 3));
      if (i % 11 == 3) rb = ra;
      if (i == 30) begin
        step("rand_reset", 1'b1, ra, rb, rf, 17'h00000);
      end else begin
        exp = model(32'(ra), 32'(rb), 32'(rf));
        step($sformatf("rand_%0d", i), 1'b0, ra, rb, rf, exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
